// File: rtl/nios_system_sysid_pkg.sv
// Shared types and constants for the system-ID checker: FSM states, slave word
// addresses and the expected ID value also published to software headers.
package nios_system_sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ID_REQ  = 3'd1,
    ST_ID_WAIT = 3'd2,
    ST_TS_REQ  = 3'd3,
    ST_TS_WAIT = 3'd4,
    ST_FIN     = 3'd5
  } sysid_state_e;

  localparam logic        SYSID_ADDR_ID           = 1'b1;
  localparam logic        SYSID_ADDR_TIMESTAMP    = 1'b0;
  localparam logic [31:0] SYSID_DEFAULT_ID        = 32'd1480900814;
  localparam logic [31:0] SYSID_DEFAULT_TIMESTAMP = 32'd0;
  localparam int unsigned SYSID_TIMER_W           = 16;

  function automatic logic is_busy_state(input sysid_state_e s);
    logic r;
    case (s)
      ST_ID_REQ, ST_ID_WAIT, ST_TS_REQ, ST_TS_WAIT: r = 1'b1;
      default:                                      r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_req_state(input sysid_state_e s);
    logic r;
    case (s)
      ST_ID_REQ, ST_TS_REQ: r = 1'b1;
      default:              r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/nios_system_sysid_timeout.sv
// Loadable down-counter for the per-transaction response timeout; expired is
// high while the count sits at zero. Used only with SYSID_CHECKER_TIMEOUT_EN.
module nios_system_sysid_timeout
  import nios_system_sysid_pkg::*;
#(
  parameter int unsigned WIDTH = SYSID_TIMER_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             expired
);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  // Load wins over counting; the count saturates at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/nios_system_sysid_checker.sv
// Avalon-MM read master that fetches the system-ID and timestamp words and
// compares them with build-time values. SYSID_CHECKER_TIMEOUT_EN adds the abort path.
module nios_system_sysid_checker
  import nios_system_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = SYSID_DEFAULT_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_DEFAULT_TIMESTAMP,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        address,
  output logic        read,
  input  logic        waitrequest,
  input  logic        readdatavalid,
  input  logic [31:0] readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  sysid_state_e state_d, state_q;
  logic         expire_s;

  logic        address_d, address_q;
  logic        read_d, read_q;
  logic        busy_d, busy_q;
  logic        done_d, done_q;
  logic        id_ok_d, id_ok_q;
  logic        ts_ok_d, ts_ok_q;
  logic        timeout_d, timeout_q;
  logic [31:0] id_value_d, id_value_q;
  logic [31:0] ts_value_d, ts_value_q;

`ifdef SYSID_CHECKER_TIMEOUT_EN
  localparam logic [SYSID_TIMER_W-1:0] TIMEOUT_LOAD = SYSID_TIMER_W'(TIMEOUT_CYCLES - 1);

  logic load_s;
  logic enable_s;
  logic expired_s;

  // Reload on entry to either request state so each transaction gets a full budget.
  always_comb begin
    load_s   = ((state_d == ST_ID_REQ) && (state_q != ST_ID_REQ)) ||
               ((state_d == ST_TS_REQ) && (state_q != ST_TS_REQ));
    enable_s = is_busy_state(state_q);
    expire_s = expired_s && enable_s;
  end

  nios_system_sysid_timeout #(
    .WIDTH (SYSID_TIMER_W)
  ) u_timeout (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (load_s),
    .load_value (TIMEOUT_LOAD),
    .enable     (enable_s),
    .expired    (expired_s)
  );
`else
  assign expire_s = 1'b0;
`endif

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      address_q  <= 1'b0;
      read_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      timeout_q  <= 1'b0;
      id_value_q <= 32'd0;
      ts_value_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      address_q  <= address_d;
      read_q     <= read_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      timeout_q  <= timeout_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
    end
  end

  // Next state: returned data takes priority over an expiring budget.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_FIN: begin
        if (start) state_d = ST_ID_REQ;
        else       state_d = state_q;
      end
      ST_ID_REQ: begin
        if (expire_s)          state_d = ST_FIN;
        else if (!waitrequest) state_d = ST_ID_WAIT;
        else                   state_d = ST_ID_REQ;
      end
      ST_ID_WAIT: begin
        if (readdatavalid) state_d = ST_TS_REQ;
        else if (expire_s) state_d = ST_FIN;
        else               state_d = ST_ID_WAIT;
      end
      ST_TS_REQ: begin
        if (expire_s)          state_d = ST_FIN;
        else if (!waitrequest) state_d = ST_TS_WAIT;
        else                   state_d = ST_TS_REQ;
      end
      ST_TS_WAIT: begin
        if (readdatavalid) state_d = ST_FIN;
        else if (expire_s) state_d = ST_FIN;
        else               state_d = ST_TS_WAIT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are derived from the next state so they register alongside it.
  always_comb begin
    address_d  = ((state_d == ST_ID_REQ) || (state_d == ST_ID_WAIT)) ? SYSID_ADDR_ID
                                                                     : SYSID_ADDR_TIMESTAMP;
    read_d     = is_req_state(state_d);
    busy_d     = is_busy_state(state_d);
    done_d     = (state_d == ST_FIN);
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    timeout_d  = timeout_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    case (state_q)
      ST_IDLE, ST_FIN: begin
        if (start) begin
          id_ok_d    = 1'b0;
          ts_ok_d    = 1'b0;
          timeout_d  = 1'b0;
          id_value_d = 32'd0;
          ts_value_d = 32'd0;
        end else begin
          timeout_d  = timeout_q;
        end
      end
      ST_ID_REQ, ST_TS_REQ: begin
        if (expire_s) timeout_d = 1'b1;
        else          timeout_d = timeout_q;
      end
      ST_ID_WAIT: begin
        if (readdatavalid) begin
          id_value_d = readdata;
          id_ok_d    = (readdata == EXPECTED_ID);
        end else if (expire_s) begin
          timeout_d  = 1'b1;
        end else begin
          timeout_d  = timeout_q;
        end
      end
      ST_TS_WAIT: begin
        if (readdatavalid) begin
          ts_value_d = readdata;
          ts_ok_d    = (readdata == EXPECTED_TIMESTAMP);
        end else if (expire_s) begin
          timeout_d  = 1'b1;
        end else begin
          timeout_d  = timeout_q;
        end
      end
      default: timeout_d = timeout_q;
    endcase
  end

  assign address  = address_q;
  assign read     = read_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign id_ok    = id_ok_q;
  assign ts_ok    = ts_ok_q;
  assign timeout  = timeout_q;
  assign id_value = id_value_q;
  assign ts_value = ts_value_q;

endmodule

// File: tb/tb_nios_system_sysid_checker.sv
// Self-checking bench for nios_system_sysid_checker: behavioural Avalon slave,
// directed vector table, randomized runs against a latency/result model, corner sequences.
module tb_nios_system_sysid_checker;

  localparam int          T      = 8;
  localparam logic [31:0] EXP_ID = 32'd1480900814;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        address;
  logic        read;
  logic        waitrequest;
  logic        readdatavalid;
  logic [31:0] readdata;
  logic        busy;
  logic        done;
  logic        id_ok;
  logic        ts_ok;
  logic        timeout;
  logic [31:0] id_value;
  logic [31:0] ts_value;

  nios_system_sysid_checker #(
    .EXPECTED_ID        (EXP_ID),
    .EXPECTED_TIMESTAMP (32'd0),
    .TIMEOUT_CYCLES     (T)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .address       (address),
    .read          (read),
    .waitrequest   (waitrequest),
    .readdatavalid (readdatavalid),
    .readdata      (readdata),
    .busy          (busy),
    .done          (done),
    .id_ok         (id_ok),
    .ts_ok         (ts_ok),
    .timeout       (timeout),
    .id_value      (id_value),
    .ts_value      (ts_value)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave configuration (written by the test) and slave bookkeeping (written by the slave)
  logic [31:0] cfg_idd, cfg_tsd, spur_data;
  int          cfg_wi, cfg_wt, cfg_di, cfg_dt;
  int          spur_cnt = 0;
  int          reads_acc = 0, stab_checks = 0, stab_fail = 0;

  typedef struct {
    logic [31:0] idd, tsd;
    int          wi, wt, di, dt;
    logic        e_id_ok, e_ts_ok;
    int          e_lat;
  } vec_t;

  typedef struct {
    logic        done, id_ok, ts_ok, tmo;
    logic [31:0] id_val, ts_val;
    int          lat, reads;
  } res_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural slave: waits cfg_w* cycles before accepting, answers cfg_d* cycles
  // after acceptance (0 = never answers), checks the command is held during stalls.
  initial begin : slave
    int   resp_cnt, wr_left, spur_seen;
    logic req_active, resp_addr, prev_wr, prev_read, prev_addr;
    resp_cnt = 0; wr_left = 0; spur_seen = 0;
    req_active = 1'b0; resp_addr = 1'b0; prev_wr = 1'b0; prev_read = 1'b0; prev_addr = 1'b0;
    waitrequest = 1'b0; readdatavalid = 1'b0; readdata = 32'd0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        resp_cnt = 0; req_active = 1'b0; prev_wr = 1'b0;
        waitrequest = 1'b0; readdatavalid = 1'b0; readdata = 32'd0;
        spur_seen = spur_cnt;
      end else begin
        if (prev_wr) begin
          stab_checks++;
          if (read !== prev_read || address !== prev_addr) begin
            stab_fail++;
            $display("FAIL cmd_stable: read=%b addr=%b, expected read=%b addr=%b (t=%0t)",
                     read, address, prev_read, prev_addr, $time);
          end
        end
        readdatavalid = 1'b0;
        readdata      = $urandom;
        if (resp_cnt > 0) begin
          resp_cnt--;
          if (resp_cnt == 0) begin
            readdatavalid = 1'b1;
            readdata      = resp_addr ? cfg_idd : cfg_tsd;
          end
        end
        if (spur_cnt != spur_seen) begin
          spur_seen     = spur_cnt;
          readdatavalid = 1'b1;
          readdata      = spur_data;
        end
        if (read) begin
          if (resp_cnt > 0) begin
            stab_fail++;
            $display("FAIL one_outstanding: read issued with %0d response cycles pending", resp_cnt);
          end
          if (!req_active) begin
            req_active = 1'b1;
            wr_left    = address ? cfg_wi : cfg_wt;
          end
          if (wr_left > 0) begin
            waitrequest = 1'b1;
            wr_left--;
          end else begin
            waitrequest = 1'b0;
            req_active  = 1'b0;
            reads_acc++;
            resp_addr   = address;
            resp_cnt    = address ? cfg_di : cfg_dt;
          end
        end else begin
          waitrequest = 1'b0;
          req_active  = 1'b0;
        end
        prev_wr = waitrequest; prev_read = read; prev_addr = address;
      end
    end
  end

  // Reference: each read costs (stall cycles + 1 request cycle + response delay);
  // with the timeout enabled a read longer than T cycles aborts the check after T cycles.
  function automatic res_t model(input logic [31:0] idd, tsd, input int wi, wt, di, dt);
    res_t r;
    bit   en;
    int   d1, d2;
`ifdef SYSID_CHECKER_TIMEOUT_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    r.done = 1'b1; r.tmo = 1'b0; r.id_ok = 1'b0; r.ts_ok = 1'b0;
    r.id_val = 32'd0; r.ts_val = 32'd0; r.reads = 1;
    d1 = (di == 0) ? 1000000 : wi + 1 + di;
    if (en && d1 > T) begin
      r.tmo = 1'b1; r.lat = T;
      return r;
    end
    r.id_val = idd; r.id_ok = (idd == EXP_ID); r.reads = 2;
    d2 = (dt == 0) ? 1000000 : wt + 1 + dt;
    if (en && d2 > T) begin
      r.tmo = 1'b1; r.lat = d1 + T;
      return r;
    end
    r.ts_val = tsd; r.ts_ok = (tsd == 32'd0); r.lat = d1 + d2;
    return r;
  endfunction

  task automatic do_run(input logic [31:0] idd, tsd, input int wi, wt, di, dt,
                        input int extra_start, output res_t o);
    int n, first, base;
    cfg_idd = idd; cfg_tsd = tsd; cfg_wi = wi; cfg_wt = wt; cfg_di = di; cfg_dt = dt;
    base = reads_acc;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    n = 0; first = -1;
    while (n < 300) begin
      if (n == 0) begin
        chk("start_clears_done", 32'(done), 32'd0);
        chk("start_clears_flags", 32'({id_ok, ts_ok, timeout}), 32'd0);
        chk("start_clears_values", id_value | ts_value, 32'd0);
        chk("busy_after_start", 32'(busy), 32'd1);
      end
      if (read && first < 0) first = n;
      if (done) break;
      n++;
      @(negedge clock);
      start = (n == extra_start);
    end
    start   = 1'b0;
    o.done  = done; o.id_ok = id_ok; o.ts_ok = ts_ok; o.tmo = timeout;
    o.id_val = id_value; o.ts_val = ts_value;
    o.lat   = (first < 0) ? -1 : n - first;
    o.reads = reads_acc - base;
    chk("busy_clear_at_done", 32'(busy), 32'd0);
    repeat (4) @(negedge clock);
  endtask

  task automatic cmp_res(input string tag, input res_t o, input res_t e);
    chk({tag, ".done"},    32'(o.done),  32'(e.done));
    chk({tag, ".id_ok"},   32'(o.id_ok), 32'(e.id_ok));
    chk({tag, ".ts_ok"},   32'(o.ts_ok), 32'(e.ts_ok));
    chk({tag, ".timeout"}, 32'(o.tmo),   32'(e.tmo));
    chk({tag, ".id_value"}, o.id_val, e.id_val);
    chk({tag, ".ts_value"}, o.ts_val, e.ts_val);
    chk({tag, ".latency"}, 32'(o.lat),   32'(e.lat));
    chk({tag, ".reads"},   32'(o.reads), 32'(e.reads));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ctrl"}, 32'({read, address, busy, done, id_ok, ts_ok, timeout}), 32'd0);
    chk({tag, ".id_value"}, id_value, 32'd0);
    chk({tag, ".ts_value"}, ts_value, 32'd0);
  endtask

  vec_t tbl[6];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    res_t o, e;
    start = 1'b0;
    cfg_idd = EXP_ID; cfg_tsd = 32'd0; cfg_wi = 0; cfg_wt = 0; cfg_di = 1; cfg_dt = 1;
    spur_data = 32'd0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1 chk_all_zero("reset_async");
    repeat (3) @(negedge clock);
    chk_all_zero("reset_held");
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    chk_all_zero("idle_after_reset");

    //            idd                     tsd             wi wt di dt  id ts  lat
    tbl[0] = '{EXP_ID,                 32'd0,          0, 0, 1, 1, 1'b1, 1'b1, 4};
    tbl[1] = '{32'h1234_5678,          32'd0,          0, 0, 1, 1, 1'b0, 1'b1, 4};
    tbl[2] = '{EXP_ID,                 32'd0,          3, 0, 3, 1, 1'b1, 1'b1, 9};
    tbl[3] = '{EXP_ID,                 32'h0000_0001,  0, 2, 1, 2, 1'b1, 1'b0, 7};
    tbl[4] = '{EXP_ID ^ 32'h8000_0000, 32'hFFFF_FFFF,  1, 1, 2, 2, 1'b0, 1'b0, 8};
    tbl[5] = '{EXP_ID,                 32'd0,          3, 0, 4, 1, 1'b1, 1'b1, 10};
    for (int i = 0; i < 6; i++) begin
      do_run(tbl[i].idd, tbl[i].tsd, tbl[i].wi, tbl[i].wt, tbl[i].di, tbl[i].dt, -1, o);
      e.done = 1'b1; e.id_ok = tbl[i].e_id_ok; e.ts_ok = tbl[i].e_ts_ok; e.tmo = 1'b0;
      e.id_val = tbl[i].idd; e.ts_val = tbl[i].tsd; e.lat = tbl[i].e_lat; e.reads = 2;
      cmp_res($sformatf("vec%0d", i), o, e);
    end

    // Randomized runs against the model
    for (int i = 0; i < 16; i++) begin
      logic [31:0] idd, tsd;
      int wi, wt, di, dt;
      idd = ($urandom_range(0, 1) == 0) ? EXP_ID : $urandom;
      tsd = ($urandom_range(0, 1) == 0) ? 32'd0  : $urandom;
      wi = $urandom_range(0, 3); wt = $urandom_range(0, 3);
`ifdef SYSID_CHECKER_TIMEOUT_EN
      di = $urandom_range(0, 6); dt = $urandom_range(0, 6);
`else
      di = $urandom_range(1, 4); dt = $urandom_range(1, 4);
`endif
      do_run(idd, tsd, wi, wt, di, dt, -1, o);
      e = model(idd, tsd, wi, wt, di, dt);
      cmp_res($sformatf("rand%0d", i), o, e);
    end

    // start while busy is ignored; the check still completes once
    do_run(EXP_ID, 32'd0, 0, 0, 1, 1, 1, o);
    cmp_res("start_busy", o, model(EXP_ID, 32'd0, 0, 0, 1, 1));
    chk("start_busy.done_held", 32'(done), 32'd1);
    chk("start_busy.no_restart", 32'(busy), 32'd0);

    // start in FIN clears the previous results (checked at first cycle) and reruns
    do_run(32'hDEAD_BEEF, 32'h5, 0, 0, 1, 1, -1, o);
    cmp_res("rerun_from_fin", o, model(32'hDEAD_BEEF, 32'h5, 0, 0, 1, 1));

`ifdef SYSID_CHECKER_TIMEOUT_EN
    // ID read never answered: abort after T cycles, no timestamp read
    do_run(EXP_ID, 32'd0, 0, 0, 0, 1, -1, o);
    e.done = 1'b1; e.id_ok = 1'b0; e.ts_ok = 1'b0; e.tmo = 1'b1;
    e.id_val = 32'd0; e.ts_val = 32'd0; e.lat = T; e.reads = 1;
    cmp_res("id_timeout", o, e);
    spur_data = EXP_ID;
    spur_cnt++;
    repeat (3) @(negedge clock);
    chk("late_rdv.id_ok", 32'(id_ok), 32'd0);
    chk("late_rdv.id_value", id_value, 32'd0);
    chk("late_rdv.state", 32'({done, busy, read, timeout}), 32'b1001);
`else
    // Without the timeout an unanswered read waits indefinitely
    cfg_di = 0;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (30) @(negedge clock);
    chk("hang.state", 32'({busy, done, read, timeout}), 32'b1000);
    reset_n = 1'b0;
    #1 chk_all_zero("hang.reset");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
`endif

    // Reset during TS_WAIT: outputs drop at once, then a clean check runs
    cfg_idd = EXP_ID; cfg_tsd = 32'd0; cfg_wi = 0; cfg_wt = 0; cfg_di = 1; cfg_dt = 6;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (4) @(negedge clock);
    chk("ts_wait.pre", 32'({busy, read, address, id_ok}), 32'b1001);
    chk("ts_wait.id_value", id_value, EXP_ID);
    reset_n = 1'b0;
    #1 chk_all_zero("mid_reset");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    chk_all_zero("after_mid_reset");
    do_run(EXP_ID, 32'd0, 0, 0, 1, 1, -1, o);
    cmp_res("post_reset", o, model(EXP_ID, 32'd0, 0, 0, 1, 1));

    chk("cmd_stable_violations", 32'(stab_fail), 32'd0);
    chk("stall_seen", 32'(stab_checks > 0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nios_system_sysid_checker.md
# nios_system_sysid_checker

Avalon-MM read master that sits on the opposite end of the system-ID slave interface: on a start pulse it reads the ID word (address 1) and the timestamp word (address 0), then compares both against compile-time expected values. Results are exposed as status levels for boot/reset sequencing logic and debug LEDs. Supports waitrequest stalls, variable read latency via readdatavalid, and an optional response timeout.

## Interface
- EXPECTED_ID, 1480900814, ID word the slave must return at address 1
- EXPECTED_TIMESTAMP, 0, timestamp word the slave must return at address 0
- TIMEOUT_CYCLES, 255, max cycles per read transaction (request plus response) before abort; range 1..65535
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to run a check
- address  out  1  word address to slave (1 = ID, 0 = timestamp)
- read  out  1  Avalon read strobe
- waitrequest  in  1  slave stall; command held while high
- readdatavalid  in  1  response data valid
- readdata  in  32  response data
- busy  out  1  check in progress
- done  out  1  check finished; held until next accepted start
- id_ok  out  1  captured ID equals EXPECTED_ID
- ts_ok  out  1  captured timestamp equals EXPECTED_TIMESTAMP
- timeout  out  1  a transaction exceeded TIMEOUT_CYCLES
- id_value  out  32  captured ID word
- ts_value  out  32  captured timestamp word

## Operation
- States: IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, FIN.
- Reset: state IDLE; all outputs 0 (address 0, read 0, flags 0, captured values 0).
- IDLE/FIN + start: clear done/id_ok/ts_ok/timeout/id_value/ts_value, go ID_REQ. start ignored in any other state.
- ID_REQ: read=1, address=1. Accepted on cycle with read=1 and waitrequest=0 → ID_WAIT.
- ID_WAIT: read=0. readdatavalid=1 → id_value←readdata, id_ok←(readdata==EXPECTED_ID), → TS_REQ.
- TS_REQ / TS_WAIT: identical with address=0, ts_value/ts_ok/EXPECTED_TIMESTAMP; TS_WAIT → FIN.
- FIN: done=1, read=0; stays until start.
- busy=1 in ID_REQ, ID_WAIT, TS_REQ, TS_WAIT.
- readdatavalid outside a WAIT state ignored (covers late responses after timeout).
- Exactly one read outstanding at any time; address and read stable while waitrequest=1.
- Comparisons are full 32-bit equality; no partial matching.

## Timing
- All outputs registered. start sampled at edge E0 → read=1 in cycle after E0.
- Zero-wait slave, readdatavalid one cycle after acceptance: done=1 four cycles after the ID read first asserts (ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, then FIN); id_ok/ts_ok valid same cycle as done.
- Each waitrequest cycle or missing-readdatavalid cycle adds one cycle.
- Timeout counter resets on entry to each REQ state, counts every cycle in REQ+WAIT; on reaching TIMEOUT_CYCLES: timeout=1, read=0, → FIN (ok flag of unfinished read stays 0; TS read skipped if ID read timed out).
- readdatavalid on the same cycle the count expires: data wins, no timeout.
- reset_n low mid-transaction: immediate return to reset values, read deasserted asynchronously.

## Configuration
- SYSID_CHECKER_TIMEOUT_EN defined: timeout counter and abort path present as above.
- Undefined: no counter; WAIT/REQ states wait indefinitely; timeout output tied 0; TIMEOUT_CYCLES unused.

## Structure
- Package nios_system_sysid_pkg: state enum, SYSID_ADDR_ID=1'b1, SYSID_ADDR_TIMESTAMP=1'b0, default expected-ID constant shared with software headers.
- One sub-module: nios_system_sysid_timeout (loadable down-counter with expire flag), instantiated only under SYSID_CHECKER_TIMEOUT_EN.

## Test plan
- Slave returns 1480900814 @addr1, 0 @addr0, zero wait → done=1, id_ok=1, ts_ok=1, timeout=0, exactly two reads, done 4 cycles after first read.
- Slave returns 0x12345678 @addr1 → done=1, id_ok=0, id_value=0x12345678, ts_ok=1.
- waitrequest high 3 cycles on ID read, readdatavalid delayed 2 cycles → address/read stable throughout, correct result, completion 5 cycles later than nominal.
- TIMEOUT_CYCLES=8, slave never asserts readdatavalid (macro on) → timeout=1 after 8 cycles, done=1, id_ok=0, no TS read issued; later spurious readdatavalid ignored.
- reset_n low during TS_WAIT → all outputs 0 immediately; after release, start runs a clean full check.
- start pulsed again while busy → ignored, single check completes; start in FIN → flags cleared, new check runs.
